// File: rtl/rx_len_checker_if.sv
// Stream bundle for rx_len_checker: 8-bit RX input stream, 32-bit result stream, sticky error flag.
interface rx_len_checker_if;
    logic        i_tready;
    logic        i_tvalid;
    logic [7:0]  i_tdata;
    logic        o_tready;
    logic        o_tvalid;
    logic [31:0] o_tdata;
    logic [3:0]  o_tkeep;
    logic        o_tlast;
    logic        o_err_sticky;

    // Checker side: sinks the RX bytes, sources the result word.
    modport master (
        output i_tready, o_tvalid, o_tdata, o_tkeep, o_tlast, o_err_sticky,
        input  i_tvalid, i_tdata, o_tready
    );

    // Environment side: sources the RX bytes, sinks the result word.
    modport slave (
        input  i_tready, o_tvalid, o_tdata, o_tkeep, o_tlast, o_err_sticky,
        output i_tvalid, i_tdata, o_tready
    );
endinterface

// File: rtl/rx_len_checker.sv
// Reads a 4-byte LE length header, checks that many incrementing payload bytes,
// and returns the mismatch count as a one-word result packet.
module rx_len_checker (
    input  logic               clk,
    input  logic               rstn,
    rx_len_checker_if.master   bus
);
    localparam int unsigned LEN_W = 32;
    localparam int unsigned IDX_W = 8;

    typedef enum logic [1:0] {S_LEN, S_DATA, S_RESULT} state_t;

    state_t               state_q, state_d;
    logic [1:0]           hdr_cnt_q, hdr_cnt_d;
    logic [23:0]          len_q, len_d;
    logic [LEN_W-1:0]     remain_q, remain_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LEN_W-1:0]     err_cnt_q, err_cnt_d;
    logic                 o_tvalid_q, o_tvalid_d;
    logic                 err_sticky_q, err_sticky_d;
    logic                 i_tready_c;
    logic                 accept_c;
    logic [LEN_W-1:0]     full_len_c;

    // Ready depends on registered state only; no path from i_tvalid.
    assign i_tready_c = (state_q != S_RESULT);
    assign accept_c   = i_tready_c & bus.i_tvalid;
    assign full_len_c = {bus.i_tdata, len_q};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_LEN;
            hdr_cnt_q    <= 2'd0;
            len_q        <= 24'd0;
            remain_q     <= '0;
            idx_q        <= '0;
            err_cnt_q    <= '0;
            o_tvalid_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            len_q        <= len_d;
            remain_q     <= remain_d;
            idx_q        <= idx_d;
            err_cnt_q    <= err_cnt_d;
            o_tvalid_q   <= o_tvalid_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        len_d        = len_q;
        remain_d     = remain_q;
        idx_d        = idx_q;
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;

        case (state_q)
            S_LEN: begin
                if (accept_c) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    case (hdr_cnt_q)
                        2'd0: len_d[7:0]   = bus.i_tdata;
                        2'd1: len_d[15:8]  = bus.i_tdata;
                        2'd2: len_d[23:16] = bus.i_tdata;
                        default: begin
                            idx_d     = '0;
                            err_cnt_d = '0;
                            if (full_len_c == '0) begin
                                state_d = S_RESULT;
                            end else begin
                                state_d  = S_DATA;
                                remain_d = full_len_c;
                            end
                        end
                    endcase
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    idx_d    = idx_q + IDX_W'(1);
                    remain_d = remain_q - LEN_W'(1);
                    if (bus.i_tdata != idx_q) begin
                        err_sticky_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + LEN_W'(1);
                        end
                    end
                    if (remain_q == LEN_W'(1)) begin
                        state_d = S_RESULT;
                    end
                end
            end
            S_RESULT: begin
                if (bus.o_tready) begin
                    state_d   = S_LEN;
                    hdr_cnt_d = 2'd0;
                end
            end
            default: state_d = S_LEN;
        endcase

        o_tvalid_d = (state_d == S_RESULT);
    end

    // Result word is the registered error count; it cannot change while in S_RESULT.
    assign bus.i_tready     = i_tready_c;
    assign bus.o_tvalid     = o_tvalid_q;
    assign bus.o_tdata      = err_cnt_q;
    assign bus.o_tkeep      = 4'hF;
    assign bus.o_tlast      = o_tvalid_q;
    assign bus.o_err_sticky = err_sticky_q;
endmodule

// File: tb/tb_rx_len_checker.sv
// Scoreboard bench for rx_len_checker: driver queues expected results, monitor
// pops and compares on each result handshake.
module tb_rx_len_checker;
    logic clk;
    logic rstn;
    rx_len_checker_if bus();

    rx_len_checker dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          pushed;
    int          popped;
    logic [31:0] exp_q[$];
    logic        exp_sticky_q[$];
    logic        sticky_model;
    logic [7:0]  pkt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every result beat against the scoreboard head.
    always @(negedge clk) begin
        if (rstn && bus.o_tvalid === 1'b1 && bus.o_tready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got 0x%08h with empty scoreboard", bus.o_tdata);
            end else begin
                logic [31:0] e;
                logic        s;
                e = exp_q.pop_front();
                s = exp_sticky_q.pop_front();
                popped++;
                check("result_data", bus.o_tdata, e);
                check("result_tlast", 32'(bus.o_tlast), 32'd1);
                check("result_tkeep", 32'(bus.o_tkeep), 32'hF);
                check("result_sticky", 32'(bus.o_err_sticky), 32'(s));
            end
        end
    end

    // Entry and exit at posedge+1.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   n;
        for (int g = 0; g < gap; g++) begin
            bus.i_tvalid = 1'b0;
            @(posedge clk); #1;
        end
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = b;
        n = 0;
        do begin
            @(negedge clk);
            rdy = bus.i_tready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) check("byte_accept_timeout", 32'd0, 32'd1);
        bus.i_tvalid = 1'b0;
    endtask

    task automatic set_hdr(input logic [31:0] len);
        pkt = {};
        pkt.push_back(len[7:0]);
        pkt.push_back(len[15:8]);
        pkt.push_back(len[23:16]);
        pkt.push_back(len[31:24]);
    endtask

    task automatic send_pkt(input logic [31:0] exp_err, input bit chk, input int maxgap);
        int last;
        sticky_model = sticky_model | (exp_err != 0);
        exp_q.push_back(exp_err);
        exp_sticky_q.push_back(sticky_model);
        pushed++;
        last = pkt.size() - 1;
        for (int i = 0; i <= last; i++) begin
            send_byte(pkt[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            if (chk && i == last - 1) begin
                @(negedge clk);
                check("ready_before_last", 32'(bus.i_tready), 32'd1);
                check("no_early_valid", 32'(bus.o_tvalid), 32'd0);
                @(posedge clk); #1;
            end
            if (chk && i == last) begin
                @(negedge clk);
                check("valid_after_last", 32'(bus.o_tvalid), 32'd1);
                check("ready_low_after_last", 32'(bus.i_tready), 32'd0);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_i_tready"}, 32'(bus.i_tready), 32'd1);
        check({tag, "_o_tvalid"}, 32'(bus.o_tvalid), 32'd0);
        check({tag, "_o_tdata"}, bus.o_tdata, 32'd0);
        check({tag, "_o_tlast"}, 32'(bus.o_tlast), 32'd0);
        check({tag, "_sticky"}, 32'(bus.o_err_sticky), 32'd0);
        check({tag, "_o_tkeep"}, 32'(bus.o_tkeep), 32'hF);
    endtask

    // Asynchronous reset pulse, issued at posedge+1 so it lands mid-cycle.
    task automatic pulse_reset(input string tag);
        rstn = 1'b0;
        #2;
        check_reset_vals(tag);
        sticky_model = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks = 0; errors = 0; pushed = 0; popped = 0;
        sticky_model = 1'b0;
        bus.i_tvalid = 1'b0;
        bus.i_tdata  = 8'h00;
        bus.o_tready = 1'b1;
        rstn = 1'b0;
        #23;
        check_reset_vals("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Zero length: result right after the 4th header byte.
        set_hdr(32'd0);
        send_pkt(32'd0, 1'b1, 0);

        // Five clean bytes.
        set_hdr(32'd5);
        for (int i = 0; i < 5; i++) pkt.push_back(8'(i));
        send_pkt(32'd0, 1'b1, 0);

        // 300 clean bytes across the 0xFF wrap with random gaps.
        set_hdr(32'd300);
        for (int i = 0; i < 300; i++) pkt.push_back(8'(i));
        send_pkt(32'd0, 1'b0, 3);

        // Two corrupted bytes, then a clean packet with sticky still set.
        set_hdr(32'd8);
        pkt.push_back(8'h00); pkt.push_back(8'h01); pkt.push_back(8'hFF); pkt.push_back(8'h03);
        pkt.push_back(8'h04); pkt.push_back(8'h05); pkt.push_back(8'hAA); pkt.push_back(8'h07);
        send_pkt(32'd2, 1'b1, 0);
        set_hdr(32'd3);
        pkt.push_back(8'h00); pkt.push_back(8'h01); pkt.push_back(8'h02);
        send_pkt(32'd0, 1'b1, 0);

        // Result backpressure: held for 10 cycles, upstream stalled.
        bus.o_tready = 1'b0;
        set_hdr(32'd3);
        pkt.push_back(8'h00); pkt.push_back(8'h05); pkt.push_back(8'h02);
        send_pkt(32'd1, 1'b1, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.o_tvalid), 32'd1);
            check("stall_data", bus.o_tdata, 32'd1);
            check("stall_ready", 32'(bus.i_tready), 32'd0);
        end
        @(posedge clk); #1;
        set_hdr(32'd3);
        pkt.push_back(8'h00); pkt.push_back(8'h01); pkt.push_back(8'h02);
        fork
            send_pkt(32'd0, 1'b0, 0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("stall_hdr_blocked", 32'(bus.i_tready), 32'd0);
                end
                bus.o_tready = 1'b1;
            end
        join

        // Reset mid-header.
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        pulse_reset("rst_hdr");

        // Reset mid-payload after an error; sticky rises right after the bad byte.
        set_hdr(32'd10);
        for (int i = 0; i < 4; i++) send_byte(pkt[i], 0);
        send_byte(8'h00, 0);
        send_byte(8'h07, 0);
        check("sticky_rise", 32'(bus.o_err_sticky), 32'd1);
        send_byte(8'h02, 0);
        pulse_reset("rst_data");

        // Fresh packet after reset.
        set_hdr(32'd3);
        pkt.push_back(8'h00); pkt.push_back(8'h01); pkt.push_back(8'h02);
        send_pkt(32'd0, 1'b1, 0);

        n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("result_count", 32'(popped), 32'(pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rx_len_checker.md
# rx_len_checker

Receive-side counterpart of the length-driven TX mass generator. Consumes the 8-bit RX AXI-stream from `ftdi_245fifo_top`, reads a 4-byte little-endian length header, then checks that exactly that many payload bytes follow an incrementing pattern. Returns a 32-bit mismatch count on a result AXI-stream that can be looped into the TX path. Also drives a sticky error flag for an LED. Sits in the user clock domain (`clk`) between the 245fifo controller's RX and TX streams.

## Interface

- No parameters. Data width is fixed at 8 bit in and 32 bit out.
- `clk` in 1: user clock, shared with the 245fifo controller's `rx_clk`/`tx_clk`.
- `rstn` in 1: asynchronous, active-low reset.
- `i_tready` out 1: RX stream ready.
- `i_tvalid` in 1: RX stream valid.
- `i_tdata` in 8: RX stream byte.
- `o_tready` in 1: result stream ready.
- `o_tvalid` out 1: result stream valid.
- `o_tdata` out 32: result word, equal to the mismatch count.
- `o_tkeep` out 4: constant `4'hF`.
- `o_tlast` out 1: equals `o_tvalid`; each result is a one-word packet.
- `o_err_sticky` out 1: set on the first mismatch since reset. Cleared only by reset.

## Operation

- A byte is accepted only when `i_tvalid & i_tready` is high in a cycle. All state advances only on accepted bytes.
- FSM has three states: `S_LEN`, `S_DATA`, `S_RESULT`.
- **`S_LEN`** (reset state)
  - `i_tready=1`.
  - Accept 4 bytes into `len[31:0]`, least-significant byte first: 1st byte → `[7:0]`, 4th byte → `[31:24]`. A 2-bit header counter tracks position.
  - On the 4th byte, clear `idx` and `err_cnt`.
  - If the assembled length is 0, go to `S_RESULT`. Otherwise go to `S_DATA` with `remain = len`.
- **`S_DATA`**
  - `i_tready=1`.
  - Expected byte is `idx[7:0]`; it wraps 0xFF→0x00.
  - On each accepted byte: increment `idx` and decrement `remain`.
  - If `i_tdata != idx[7:0]`: increment `err_cnt` (saturating at `32'hFFFFFFFF`) and set `o_err_sticky`.
  - When the byte accepted has `remain==1`, go to `S_RESULT`.
- **`S_RESULT`**
  - `i_tready=0`.
  - `o_tvalid=1` and `o_tdata` holds the final `err_cnt`, including any error on the last byte.
  - On `o_tvalid & o_tready`: return to `S_LEN` and clear the header counter.
- Incoming bytes are never dropped. Upstream is stalled while a result is pending.

## Timing

- Reset values: state `S_LEN`, `i_tready=1`, `o_tvalid=0`, `o_tdata=0`, `o_tlast=0`, `o_err_sticky=0`, all counters 0. `o_tkeep` is always `4'hF`.
- `i_tready` is decoded combinationally from the registered state only. It has no combinational path from `i_tvalid`.
- `o_tvalid` and `o_tdata` are registered.
- Result latency: `o_tvalid` rises on the cycle after the last payload byte is accepted. For length 0, it rises on the cycle after the 4th header byte.
- `o_tdata` is stable while `o_tvalid=1 & o_tready=0`. `o_tvalid` stays high until the handshake.
- `o_tvalid` drops on the cycle after the handshake. `i_tready` is 1 in that same cycle, so the next header can start immediately.
- `i_tvalid` gaps of any length are allowed in `S_LEN`/`S_DATA`; state holds.
- Max length is `2^32-1`, counted with a 32-bit `remain`. `idx` only needs 8 bits.
- `o_err_sticky` rises on the cycle after the offending byte is accepted.
- Asserting `rstn` low in any state, including mid-header or mid-payload, immediately forces all reset values. Partial header and partial payload are discarded.

## Test plan

- Header `00 00 00 00`, `o_tready=1` → one result beat `o_tdata=0`, `o_tlast=1`, issued on the cycle after the 4th byte; `o_err_sticky=0`.
- Header `05 00 00 00`, payload `00 01 02 03 04` → `o_tdata=0`. `i_tready` goes low only after the 5th byte.
- Header `2C 01 00 00` (300), correct payload 0x00..0xFF then 0x00..0x2B, random `i_tvalid` gaps → `o_tdata=0`, which checks the wrap.
- Header `08 00 00 00`, payload `00 01 FF 03 04 05 AA 07` → `o_tdata=2`, `o_err_sticky=1`. A following clean 3-byte packet returns `o_tdata=0` while `o_err_sticky` stays 1.
- Result with `o_tready=0` for 10 cycles → `o_tvalid` and `o_tdata` are held and `i_tready=0` throughout. Next header bytes are accepted only after the handshake.
- `rstn` pulsed low after 2 header bytes, and separately mid-payload → outputs return to reset values. A fresh `03 00 00 00 00 01 02` then yields `o_tdata=0`.
